// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: widths, RV32I funct3 codes,
// FSM state encoding and the access legality check.
package load_store_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE
    } lsu_state_t;

    // Legal funct3 for the direction and naturally aligned for the access size.
    function automatic logic access_ok(input logic       store,
                                       input logic [2:0] funct,
                                       input logic [1:0] addr_lo);
        logic ok;
        case (funct)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !store;
            F3_H:    ok = !addr_lo[0];
            F3_HU:   ok = !store && !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_aligner.sv
// Load lane select and sign/zero extension of a bus word into the
// writeback value, driven by the low address bits and funct3.
module load_aligner
    import load_store_unit_pkg::*;
(
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{addr_lo, 3'b000} +: 8];
        half_lane = word[{addr_lo[1], 4'b0000} +: 16];
        case (funct)
            F3_B:    result = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            F3_BU:   result = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            F3_H:    result = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            F3_HU:   result = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: checks alignment/funct3, runs one
// read or write on the data bus with valid/ready handshakes, returns the result.
//
// state      | meaning
// IDLE       | waiting for lsu_start
// RD_ADDR    | read address valid, waiting for dr_addr_ready
// RD_DATA    | dr_data_ready high, waiting for read data
// WR_REQ     | write request valid, waiting for dw_ready
// WR_RESP    | dw_resp_ready high, waiting for write response
// DONE       | one-cycle completion pulse, lsu_error qualified
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_start,
    input  logic                  lsu_store,
    input  logic [2:0]            lsu_funct,
    input  logic [DATA_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_busy,
    output logic                  lsu_done,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_error,
    output logic                  dr_addr_valid,
    input  logic                  dr_addr_ready,
    output logic [DATA_WIDTH-1:0] dr_addr,
    input  logic                  dr_data_valid,
    output logic                  dr_data_ready,
    input  logic [DATA_WIDTH-1:0] dr_data,
    output logic                  dw_valid,
    input  logic                  dw_ready,
    output logic [DATA_WIDTH-1:0] dw_addr,
    output logic [DATA_WIDTH-1:0] dw_data,
    output logic [STRB_WIDTH-1:0] dw_strobe,
    input  logic                  dw_resp_valid,
    output logic                  dw_resp_ready,
    input  logic                  dw_resp
);

    lsu_state_t            state, state_next;
    logic [2:0]            funct_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] dw_data_q;
    logic [STRB_WIDTH-1:0] dw_strobe_q;
    logic                  error_q;
    logic                  start_ok;
    logic                  accept;
    logic [DATA_WIDTH-1:0] load_result;
    logic [DATA_WIDTH-1:0] store_data;
    logic [STRB_WIDTH-1:0] store_strb;

    assign accept   = (state == ST_IDLE) && lsu_start;
    assign start_ok = access_ok(lsu_store, lsu_funct, lsu_addr[1:0]);

    load_aligner u_aligner (
        .addr_lo (addr_q[1:0]),
        .funct   (funct_q),
        .word    (dr_data),
        .result  (load_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (lsu_start) begin
                    if (!start_ok)      state_next = ST_DONE;
                    else if (lsu_store) state_next = ST_WR_REQ;
                    else                state_next = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: if (dr_addr_ready) state_next = ST_RD_DATA;
            ST_RD_DATA: if (dr_data_valid) state_next = ST_DONE;
            ST_WR_REQ:  if (dw_ready)      state_next = ST_WR_RESP;
            ST_WR_RESP: if (dw_resp_valid) state_next = ST_DONE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Lane replication and strobes are formed at accept so the channel is registered.
    always_comb begin
        store_data = lsu_wdata;
        store_strb = '1;
        case (lsu_funct)
            F3_B: begin
                store_data = {4{lsu_wdata[7:0]}};
                store_strb = 4'b0001 << lsu_addr[1:0];
            end
            F3_H: begin
                store_data = {2{lsu_wdata[15:0]}};
                store_strb = 4'b0011 << lsu_addr[1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct_q     <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            dw_data_q   <= '0;
            dw_strobe_q <= '0;
            error_q     <= 1'b0;
        end else begin
            if (accept) begin
                funct_q <= lsu_funct;
                addr_q  <= lsu_addr;
                error_q <= !start_ok;
                if (start_ok && lsu_store) begin
                    dw_data_q   <= store_data;
                    dw_strobe_q <= store_strb;
                end
            end
            if (state == ST_RD_DATA && dr_data_valid) rdata_q <= load_result;
            if (state == ST_WR_RESP && dw_resp_valid) error_q <= dw_resp;
        end
    end

    assign lsu_busy      = (state != ST_IDLE);
    assign lsu_done      = (state == ST_DONE);
    assign lsu_error     = (state == ST_DONE) && error_q;
    assign lsu_rdata     = rdata_q;
    assign dr_addr_valid = (state == ST_RD_ADDR);
    assign dr_addr       = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign dr_data_ready = (state == ST_RD_DATA);
    assign dw_valid      = (state == ST_WR_REQ);
    assign dw_addr       = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign dw_data       = dw_data_q;
    assign dw_strobe     = dw_strobe_q;
    assign dw_resp_ready = (state == ST_WR_RESP);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses against a
// behavioural model, with a bus slave that injects stalls and errors.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_start = 1'b0, lsu_store = 1'b0;
    logic [2:0]  lsu_funct = '0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic        lsu_busy, lsu_done, lsu_error;
    logic [31:0] lsu_rdata;
    logic        dr_addr_valid, dr_addr_ready = 1'b0;
    logic [31:0] dr_addr;
    logic        dr_data_valid = 1'b0, dr_data_ready;
    logic [31:0] dr_data = '0;
    logic        dw_valid, dw_ready = 1'b0;
    logic [31:0] dw_addr, dw_data;
    logic [3:0]  dw_strobe;
    logic        dw_resp_valid = 1'b0, dw_resp_ready, dw_resp = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .lsu_start(lsu_start), .lsu_store(lsu_store), .lsu_funct(lsu_funct),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_error(lsu_error),
        .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
        .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
        .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr), .dw_data(dw_data),
        .dw_strobe(dw_strobe),
        .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready), .dw_resp(dw_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(bit st, logic [2:0] f, logic [31:0] a);
        int unsigned size;
        if (st ? (f > 3'd2) : (f == 3'd3 || f > 3'd5)) return 1'b0;
        size = 1 << f[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [2:0] f, logic [31:0] a);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        case (f)
            3'd0:    return 32'($signed(v[7:0]));
            3'd1:    return 32'($signed(v[15:0]));
            3'd4:    return v & 32'hFF;
            3'd5:    return v & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(logic [31:0] wd, logic [2:0] f);
        if (f == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_strobe(logic [2:0] f, logic [31:0] a);
        if (f == 3'd0) return 32'((1 << (a % 4)) & 15);
        if (f == 3'd1) return 32'((3 << (a % 4)) & 15);
        return 32'hF;
    endfunction

    // Called at a negedge with the DUT idle; that negedge starts cycle 0.
    task automatic access(input bit st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word,
                          input int a_stall, input int d_stall, input bit resp,
                          input bit early, input int pulse_cyc, input string tag);
        bit legal;
        bit any_valid;
        int acnt, dcnt, done_cyc, first_valid;
        legal = ref_legal(st, f, a);
        any_valid = 1'b0;
        acnt = 0; dcnt = 0; done_cyc = -1; first_valid = -1;
        lsu_start = 1'b1; lsu_store = st; lsu_funct = f; lsu_addr = a; lsu_wdata = wd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            lsu_start = (c == pulse_cyc);
            lsu_addr  = $urandom;
            lsu_wdata = $urandom;
            lsu_funct = 3'($urandom_range(0, 2));
            lsu_store = 1'($urandom_range(0, 1));
            if (lsu_done) begin
                done_cyc = c;
                if (legal && !st) exp_rdata = ref_load(word, f, a);
                chk({tag, " error"}, 32'(lsu_error), 32'(!legal || (st && resp)));
                chk({tag, " rdata"}, lsu_rdata, exp_rdata);
                lsu_start = 1'b0;
                dr_addr_ready = 1'b0; dr_data_valid = 1'b0;
                dw_ready = 1'b0; dw_resp_valid = 1'b0;
                break;
            end
            chk({tag, " busy"}, 32'(lsu_busy), 32'd1);
            if (dr_addr_valid || dw_valid) begin
                any_valid = 1'b1;
                if (first_valid < 0) first_valid = c;
            end
            if (dr_addr_valid) begin
                chk({tag, " dr_addr"}, dr_addr, a & ~32'h3);
                dr_addr_ready = (acnt >= a_stall);
                acnt++;
                dr_data_valid = early;
                dr_data = ~word;
            end else if (dr_data_ready) begin
                dr_addr_ready = 1'b0;
                dr_data_valid = (dcnt >= d_stall);
                dcnt++;
                dr_data = dr_data_valid ? word : ~word;
            end else begin
                dr_addr_ready = 1'b0;
                dr_data_valid = 1'b0;
            end
            if (dw_valid) begin
                chk({tag, " dw_addr"}, dw_addr, a & ~32'h3);
                chk({tag, " dw_data"}, dw_data, ref_wdata(wd, f));
                chk({tag, " dw_strobe"}, 32'(dw_strobe), ref_strobe(f, a));
                dw_ready = (acnt >= a_stall);
                acnt++;
                dw_resp_valid = early;
                dw_resp = !resp;
            end else if (dw_resp_ready) begin
                dw_ready = 1'b0;
                dw_resp_valid = (dcnt >= d_stall);
                dcnt++;
                dw_resp = dw_resp_valid ? resp : !resp;
            end else begin
                dw_ready = 1'b0;
                dw_resp_valid = 1'b0;
            end
        end
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'(legal ? 3 + a_stall + d_stall : 1));
        if (legal) chk({tag, " first_valid_cycle"}, 32'(first_valid), 32'd1);
        else       chk({tag, " no_bus_traffic"}, 32'(any_valid), 32'd0);
        lsu_start = 1'b0;
        @(negedge clk);
        chk({tag, " done_pulse_end"}, {30'd0, lsu_done, lsu_busy}, 32'd0);
    endtask

    initial begin
        bit          r_st, r_resp, r_early;
        logic [2:0]  r_f;
        logic [31:0] r_a;

        repeat (2) @(negedge clk);
        #1;
        chk("reset busy/done/error", {29'd0, lsu_busy, lsu_done, lsu_error}, 32'd0);
        chk("reset valids/readies",
            {27'd0, dr_addr_valid, dr_data_ready, dw_valid, dw_resp_ready, 1'b0}, 32'd0);
        chk("reset rdata", lsu_rdata, 32'd0);
        chk("reset dr_addr", dr_addr, 32'd0);
        chk("reset dw_addr", dw_addr, 32'd0);
        chk("reset dw_data", dw_data, 32'd0);
        chk("reset dw_strobe", 32'(dw_strobe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        access(0, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0, 0, "LW_0x100");
        chk("LW literal", lsu_rdata, 32'hDEADBEEF);
        access(0, F3_B,  32'h103, 32'h0, 32'h80123456, 0, 0, 0, 0, 0, "LB_0x103");
        chk("LB literal", lsu_rdata, 32'hFFFFFF80);
        access(0, F3_BU, 32'h103, 32'h0, 32'h80123456, 0, 0, 0, 0, 0, "LBU_0x103");
        chk("LBU literal", lsu_rdata, 32'h00000080);
        access(0, F3_H,  32'h102, 32'h0, 32'h80123456, 0, 0, 0, 0, 0, "LH_0x102");
        chk("LH literal", lsu_rdata, 32'hFFFF8012);
        access(0, F3_HU, 32'h102, 32'h0, 32'h80123456, 0, 0, 0, 0, 0, "LHU_0x102");
        chk("LHU literal", lsu_rdata, 32'h00008012);

        access(1, F3_B, 32'h201, 32'h000000AB, 32'h0, 0, 0, 0, 0, 0, "SB_0x201");
        access(1, F3_H, 32'h202, 32'h00001234, 32'h0, 0, 0, 0, 0, 0, "SH_0x202");

        access(0, F3_W, 32'h102, 32'h0, 32'h11111111, 0, 0, 0, 0, 0, "LW_misaligned");
        access(1, F3_H, 32'h301, 32'h5555, 32'h0, 0, 0, 0, 0, 0, "SH_misaligned");
        access(0, 3'b011, 32'h100, 32'h0, 32'h22222222, 0, 0, 0, 0, 0, "LD_illegal");
        chk("rdata after errors", lsu_rdata, 32'h00008012);

        access(0, F3_W, 32'h104, 32'h0, 32'hCAFEF00D, 3, 2, 0, 1, 4, "LW_stalled");
        access(1, F3_W, 32'h308, 32'hA5A5A5A5, 32'h0, 1, 1, 1, 1, 2, "SW_resp_err");

        // Reset while waiting for read data: everything returns to reset values.
        lsu_start = 1'b1; lsu_store = 1'b0; lsu_funct = F3_W; lsu_addr = 32'h400;
        @(negedge clk);
        lsu_start = 1'b0;
        dr_addr_ready = 1'b1;
        @(negedge clk);
        dr_addr_ready = 1'b0;
        chk("pre-reset dr_data_ready", 32'(dr_data_ready), 32'd1);
        rst = 1'b1;
        #1;
        exp_rdata = '0;
        chk("mid-access reset status", {29'd0, lsu_busy, lsu_done, dr_data_ready}, 32'd0);
        chk("mid-access reset dr_addr", dr_addr, 32'd0);
        chk("mid-access reset rdata", lsu_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dr_data_valid = 1'b1;
        dr_data = 32'h77777777;
        @(negedge clk);
        dr_data_valid = 1'b0;
        chk("post-reset no done", {30'd0, lsu_done, lsu_busy}, 32'd0);
        access(0, F3_H, 32'h406, 32'h0, 32'h9ABC1234, 0, 0, 0, 0, 0, "LH_after_reset");

        for (int i = 0; i < 24; i++) begin
            r_st    = 1'($urandom_range(0, 1));
            r_f     = 3'($urandom_range(0, 7));
            r_a     = $urandom;
            if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
            r_resp  = ($urandom_range(0, 3) == 0);
            r_early = 1'($urandom_range(0, 1));
            access(r_st, r_f, r_a, $urandom, $urandom,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   r_resp, r_early, 0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
